ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 device-to-host receiver with an output FIFO, for mouse and keyboard streams.
//  - Synchronises and glitch-filters PS2C/PS2D.
//  - Decodes 11-bit frames LSB-first and checks start, odd parity and stop bits.
//  - Enforces an inter-edge timeout.
//  - Queues good bytes in a FIFO read through a valid/ready handshake.
//  Sits between the PS/2 pins and the mouse packet assembler. Runs entirely on qzt_clk.
// PARAMETERS
//  CLK_HZ      25000000  qzt_clk frequency in Hz; used only to derive TIMEOUT_CYC
//  DATA_BITS   8         payload bits per frame (1..16)
//  PARITY_EN   1         1 = expect an odd-parity bit after the payload; 0 = no parity bit
//  FILTER_LEN  8         consecutive equal samples needed to accept a line change (2..255)
//  TIMEOUT_US  2000      maximum gap between falling edges inside a frame, in us
//  DEPTH       4         FIFO entries; power of two, 2..64
// PORTS
//  qzt_clk    in   1                    system clock
//  reset      in   1                    synchronous, active-high reset
//  enable     in   1                    0 = receiver held in IDLE, frame in progress discarded silently
//  PS2C       in   1                    raw PS/2 clock pin (asynchronous)
//  PS2D       in   1                    raw PS/2 data pin (asynchronous)
//  data       out  DATA_BITS            FIFO head byte; valid only while data_valid = 1
//  data_valid out  1                    FIFO not empty
//  data_ready in   1                    consumer pop; a pop occurs when data_valid & data_ready
//  count      out  $clog2(DEPTH)+1      FIFO occupancy
//  err_parity out  1                    1-cycle pulse: parity mismatch, byte dropped
//  err_frame  out  1                    1-cycle pulse: stop bit = 0, byte dropped
//  err_tout   out  1                    1-cycle pulse: inter-edge timeout, frame dropped
//  overflow   out  1                    1-cycle pulse: good byte arrived while FIFO full, byte dropped
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, FIFO empty, filters preset to 1 (bus idle). A reset mid-frame discards the frame.
//  Input path: 2-FF synchroniser per line, then a filter.
//   - The filter output changes only after FILTER_LEN consecutive identical synchronised samples.
//   - A falling edge (fedge) is a 1-cycle strobe when the filtered PS2C goes 1->0.
//   - Each bit is sampled as the filtered PS2D in the fedge cycle.
//  FSM, advancing only on fedge unless noted:
//   - IDLE: on fedge with bit = 0 go to DATA, nbits = 0. A start bit of 1 is ignored and FSM stays in IDLE.
//   - DATA: shift the bit in LSB-first. After DATA_BITS bits go to PARITY if PARITY_EN, else to STOP.
//   - PARITY: store the bit. Parity is good when the payload ^ parity has odd weight.
//   - STOP: if bit = 0, pulse err_frame. Else if parity is bad, pulse err_parity. Else push. Then go to IDLE.
//   - err_frame takes precedence over err_parity.
//  Timeout:
//   - TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US.
//   - A counter clears on every fedge and in IDLE, and increments in every other state.
//   - When it reaches TIMEOUT_CYC: pulse err_tout, go to IDLE, discard the partial frame.
//  enable = 0: forces IDLE and clears nbits and the timeout counter. No error pulse. The FIFO is unaffected and stays readable.
//  Push latency: byte is visible at data with data_valid = 1 on the cycle after the stop-bit fedge.
//  FIFO:
//   - Circular buffer, pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle are both performed and count is unchanged; this holds even when full.
//   - Push when full with no pop: byte dropped, overflow pulses, contents unchanged.
//   - Pop when empty is ignored.
//   - data is registered head-of-queue and is stable while data_valid & !data_ready.
//  Error and overflow pulses last exactly 1 cycle and never assert together with a push.
// TESTING (CLK_HZ = 25e6, defaults unless noted; PS/2 bit period 80 us)
//  1 Frame 0x5A (start 0, bits LSB-first, parity 1, stop 1) -> data = 0x5A, data_valid 1 cycle after stop fedge, count = 1, no error pulses.
//  2 Frame 0x00 sent with parity 0 -> err_parity for 1 cycle, count stays 0. Frame 0xFF sent with stop 0 -> err_frame only.
//  3 Drive 3-cycle low glitches on PS2C while idle, then send valid 0x12 -> no spurious frame, data = 0x12.
//  4 Stop PS2C after 5 bits for 2.1 ms -> err_tout pulses once, FSM returns to IDLE, next frame 0x34 is received correctly.
//  5 data_ready = 0, send 5 frames 0x01..0x05 -> count = 4, overflow pulses once on the 5th. Then pop with ready = 1 -> bytes 0x01..0x04 in order.
//  6 With the FIFO full, pop on the exact cycle a push lands -> count stays 4, no overflow. Assert reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bundle of the PS/2 receiver: FIFO head, occupancy and the pop handshake.
interface ps2_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
);
    logic [DATA_BITS-1:0]   data;
    logic                   data_valid;
    logic                   data_ready;
    logic [$clog2(DEPTH):0] count;

    modport master (output data, output data_valid, output count, input data_ready);
    modport slave  (input data, input data_valid, input count, output data_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and filtered lines, frame decoder with
// parity/stop/timeout checks, and a small output FIFO read through valid/ready.
module ps2_rx_fifo #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic          qzt_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          PS2C,
    input  logic          PS2D,
    ps2_rx_fifo_if.master rx,
    output logic          err_parity,
    output logic          err_frame,
    output logic          err_tout,
    output logic          overflow
);
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned NW = $clog2(DATA_BITS + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Line conditioning; index 0 = PS2C, index 1 = PS2D
    logic [1:0] r_meta, r_sync, r_filt;
    logic [7:0] r_fcnt [0:1];
    logic       r_c_prev;
    logic       w_fedge, w_bit;

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_meta   <= '1;
            r_sync   <= '1;
            r_filt   <= '1;
            r_c_prev <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) r_fcnt[i] <= '0;
        end else begin
            r_meta   <= {PS2D, PS2C};
            r_sync   <= r_meta;
            r_c_prev <= r_filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == 8'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_fedge = r_c_prev & ~r_filt[0];
    assign w_bit   = r_filt[1];

    state_t                 r_state, w_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS:0]     w_shift_nx;
    logic [NW-1:0]          r_nbits;
    logic [TW-1:0]          r_tcnt;
    logic                   r_par;
    logic                   w_tout, w_par_ok, w_last_data;
    logic                   w_push, w_err_frame, w_err_parity;

    assign w_shift_nx  = {w_bit, r_shift};
    assign w_last_data = (r_nbits == NW'(DATA_BITS - 1));
    assign w_par_ok    = (PARITY_EN == 0) || (^{r_shift, r_par});
    // A fedge in the same cycle as expiry restarts the gap instead of aborting
    assign w_tout      = enable && (r_state != IDLE) && !w_fedge && (r_tcnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge qzt_clk) begin
        if (reset || !enable) r_state <= IDLE;
        else                  r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_tout) begin
            w_next = IDLE;
        end else if (w_fedge) begin
            case (r_state)
                IDLE:    if (!w_bit) w_next = DATA;
                DATA:    if (w_last_data) w_next = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  w_next = STOP;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_push       = 1'b0;
        w_err_frame  = 1'b0;
        w_err_parity = 1'b0;
        if (enable && w_fedge && r_state == STOP) begin
            if (!w_bit)         w_err_frame  = 1'b1;
            else if (!w_par_ok) w_err_parity = 1'b1;
            else                w_push       = 1'b1;
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_shift <= '0;
            r_nbits <= '0;
            r_tcnt  <= '0;
            r_par   <= 1'b0;
        end else if (!enable) begin
            r_nbits <= '0;
            r_tcnt  <= '0;
        end else begin
            if (w_fedge || r_state == IDLE || w_tout) r_tcnt <= '0;
            else                                      r_tcnt <= r_tcnt + TW'(1);
            if (w_fedge) begin
                case (r_state)
                    IDLE: r_nbits <= '0;
                    DATA: begin
                        r_shift <= w_shift_nx[DATA_BITS:1];
                        r_nbits <= r_nbits + NW'(1);
                    end
                    PARITY:  r_par <= w_bit;
                    default: ;
                endcase
            end
        end
    end

    logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0]        r_wr, r_rd;
    logic [CW-1:0]        r_count;
    logic                 w_pop, w_full, w_wr;

    assign w_pop  = (r_count != '0) && rx.data_ready;
    assign w_full = (r_count == CW'(DEPTH));
    // When full, a simultaneous pop frees the head slot, so the push lands at the tail
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            err_tout   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= r_shift;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
            err_parity <= w_err_parity;
            err_frame  <= w_err_frame;
            err_tout   <= w_tout;
            overflow   <= w_push && w_full && !w_pop;
        end
    end

    assign rx.data       = r_mem[r_rd];
    assign rx.data_valid = (r_count != '0);
    assign rx.count      = r_count;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with a scaled clock (1 MHz, 32-cycle PS/2 bit, 200-cycle timeout).
module tb_ps2_rx_fifo;
    localparam int HALF = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic PS2C = 1'b1;
    logic PS2D = 1'b1;
    logic err_parity, err_frame, err_tout, overflow;
    int   n_vec = 0, n_bad = 0;
    int   n_perr = 0, n_ferr = 0, n_tout = 0, n_ovf = 0;
    logic [10:0] f;

    ps2_rx_fifo_if #(.DATA_BITS(8), .DEPTH(4)) rx_if ();

    ps2_rx_fifo #(
        .CLK_HZ(1000000), .DATA_BITS(8), .PARITY_EN(1),
        .FILTER_LEN(8), .TIMEOUT_US(200), .DEPTH(4)
    ) dut (
        .qzt_clk(clk), .reset(reset), .enable(enable), .PS2C(PS2C), .PS2D(PS2D),
        .rx(rx_if),
        .err_parity(err_parity), .err_frame(err_frame), .err_tout(err_tout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity) n_perr++;
        if (err_frame)  n_ferr++;
        if (err_tout)   n_tout++;
        if (overflow)   n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] v, input logic flip, input logic stopb);
        return {stopb, (~^v) ^ flip, v, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            PS2D = fr[i];
            tick(HALF);
            PS2C = 1'b0;
            tick(HALF);
            PS2C = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] v);
        send_bits(mkframe(v, 1'b0, 1'b1), 11);
        PS2D = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] v);
        chk({tag, "_valid"}, rx_if.data_valid, 1);
        chk(tag, rx_if.data, v);
        rx_if.data_ready = 1'b1;
        tick(1);
        rx_if.data_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.data_ready = 1'b0;
        tick(4);
        chk("rst_valid", rx_if.data_valid, 0);
        chk("rst_count", rx_if.count, 0);
        chk("rst_data", rx_if.data, 0);
        chk("rst_errs", {err_parity, err_frame, err_tout, overflow}, 0);
        reset = 1'b0;
        tick(4);

        // Stop fedge lands 10 edges after PS2C falls (2 sync + 8 filter); push shows on the 11th
        f = mkframe(8'h5A, 1'b0, 1'b1);
        send_bits(f, 10);
        PS2D = f[10];
        tick(HALF);
        PS2C = 1'b0;
        tick(10);
        chk("t1_early", rx_if.data_valid, 0);
        tick(1);
        chk("t1_valid", rx_if.data_valid, 1);
        chk("t1_data", rx_if.data, 8'h5A);
        chk("t1_count", rx_if.count, 1);
        tick(HALF - 11);
        PS2C = 1'b1;
        tick(2 * HALF);
        chk("t1_errs", n_perr + n_ferr + n_tout + n_ovf, 0);
        pop_exp("t1_pop", 8'h5A);
        chk("t1_empty", rx_if.count, 0);

        send_bits(mkframe(8'h00, 1'b1, 1'b1), 11);
        PS2D = 1'b1;
        tick(2 * HALF);
        chk("t2_perr", n_perr, 1);
        chk("t2_ferr0", n_ferr, 0);
        chk("t2_count0", rx_if.count, 0);
        send_bits(mkframe(8'hFF, 1'b0, 1'b0), 11);
        PS2D = 1'b1;
        tick(2 * HALF);
        chk("t2_ferr", n_ferr, 1);
        chk("t2_perr1", n_perr, 1);
        chk("t2_count1", rx_if.count, 0);

        repeat (5) begin
            PS2C = 1'b0;
            tick(3);
            PS2C = 1'b1;
            tick(20);
        end
        chk("t3_noglitch", rx_if.count, 0);
        chk("t3_errs", n_perr + n_ferr + n_tout, 2);
        send_frame(8'h12);
        pop_exp("t3_pop", 8'h12);

        send_bits(mkframe(8'h34, 1'b0, 1'b1), 5);
        tick(300);
        chk("t4_tout", n_tout, 1);
        chk("t4_count", rx_if.count, 0);
        send_frame(8'h34);
        pop_exp("t4_pop", 8'h34);
        chk("t4_tout_once", n_tout, 1);

        for (int v = 1; v <= 5; v++) send_frame(8'(v));
        chk("t5_count", rx_if.count, 4);
        chk("t5_ovf", n_ovf, 1);
        for (int v = 1; v <= 4; v++) pop_exp("t5_pop", 8'(v));
        chk("t5_empty", rx_if.count, 0);

        for (int v = 8'h11; v <= 8'h14; v++) send_frame(8'(v));
        chk("t6_full", rx_if.count, 4);
        f = mkframe(8'h15, 1'b0, 1'b1);
        send_bits(f, 10);
        PS2D = f[10];
        tick(HALF);
        PS2C = 1'b0;
        tick(10);
        rx_if.data_ready = 1'b1;
        tick(1);
        rx_if.data_ready = 1'b0;
        chk("t6_count", rx_if.count, 4);
        tick(HALF - 11);
        PS2C = 1'b1;
        tick(2 * HALF);
        chk("t6_noovf", n_ovf, 1);
        for (int v = 8'h12; v <= 8'h15; v++) pop_exp("t6_pop", 8'(v));

        send_frame(8'h42);
        send_bits(mkframe(8'h7E, 1'b0, 1'b1), 4);
        reset = 1'b1;
        tick(1);
        chk("t7_valid", rx_if.data_valid, 0);
        chk("t7_count", rx_if.count, 0);
        chk("t7_data", rx_if.data, 0);
        chk("t7_errs", {err_parity, err_frame, err_tout, overflow}, 0);
        reset = 1'b0;
        PS2D = 1'b1;
        tick(4);
        send_frame(8'h7E);
        pop_exp("t7_pop", 8'h7E);

        send_bits(mkframe(8'h55, 1'b0, 1'b1), 4);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(300);
        chk("t8_notout", n_tout, 1);
        chk("t8_count", rx_if.count, 0);
        send_frame(8'h66);
        pop_exp("t8_pop", 8'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
